// File: rtl/mux4way_rr_arbiter_pkg.sv
// Shared definitions for the 4-way round-robin arbiter: state encoding,
// requester count and select width, and a one-hot to index helper.
package mux4way_rr_arbiter_pkg;

   localparam int unsigned REQ_N = 4;
   localparam int unsigned SEL_W = 2;

   typedef enum logic [0:0] {
      ST_IDLE  = 1'b0,
      ST_GRANT = 1'b1
   } arb_state_e;

   // Result of a round-robin scan: whether any requester was found, and which.
   typedef struct packed {
      logic             found;
      logic [SEL_W-1:0] idx;
   } rr_pick_t;

   // Index of the set bit of a one-hot vector; zero when the vector is empty.
   function automatic logic [SEL_W-1:0] onehot_to_idx(input logic [REQ_N-1:0] oh);
      logic [SEL_W-1:0] idx;
      idx = {SEL_W{1'b0}};
      for (int i = 0; i < REQ_N; i++) begin
         if (oh[i]) begin
            idx = SEL_W'(i);
         end
      end
      return idx;
   endfunction

endpackage

// File: rtl/mux4way_rr_arbiter_if.sv
// Bus between the four producers and the arbiter: requests, per-requester
// data bits, and the grant/select/data results.
interface mux4way_rr_arbiter_if;
   import mux4way_rr_arbiter_pkg::*;

   logic [REQ_N-1:0] req;
   logic             inA;
   logic             inB;
   logic             inC;
   logic             inD;
   logic [REQ_N-1:0] grant;
   logic [SEL_W-1:0] select;
   logic             grantValid;
   logic             dataOut;

   // Producer side: raises requests and presents data, observes the grant.
   modport master (
      output req, inA, inB, inC, inD,
      input  grant, select, grantValid, dataOut
   );

   // Arbiter side.
   modport slave (
      input  req, inA, inB, inC, inD,
      output grant, select, grantValid, dataOut
   );

endinterface

// File: rtl/mux4way_rr_arbiter_chk.sv
// Structural invariants of the arbiter outputs: grant is one-hot or empty,
// grantValid mirrors a non-empty grant, and select points at the granted bit.
module mux4way_rr_arbiter_chk
   import mux4way_rr_arbiter_pkg::*;
(
   input logic             clk,
   input logic             rst_n,
   input logic [REQ_N-1:0] grant,
   input logic [SEL_W-1:0] select,
   input logic             grantValid
);

   a_grant_onehot0 : assert property (@(posedge clk) disable iff (!rst_n)
      $onehot0(grant));

   a_valid_matches : assert property (@(posedge clk) disable iff (!rst_n)
      grantValid == (|grant));

   a_select_matches : assert property (@(posedge clk) disable iff (!rst_n)
      grantValid |-> grant[select]);

endmodule

// File: rtl/mux4way_rr_arbiter_mux4way.sv
// Plain 1-bit 4-to-1 multiplexer shared by the arbiter's requesters.
module mux4way (
   output logic       out,
   input  logic [1:0] select,
   input  logic       inA,
   input  logic       inB,
   input  logic       inC,
   input  logic       inD
);

   // Route the selected input to the output.
   always_comb begin
      out = 1'b0;
      case (select)
         2'd0:    out = inA;
         2'd1:    out = inB;
         2'd2:    out = inC;
         2'd3:    out = inD;
         default: out = 1'b0;
      endcase
   end

endmodule

// File: rtl/mux4way_rr_arbiter.sv
// Round-robin arbiter sharing one 1-bit Mux4way between four requesters.
// Grant, select and valid are registered; an owner holding the grant while
// others wait is forced off after MAX_HOLD consecutive cycles. The muxed bit
// is gated combinationally by grant validity.
module mux4way_rr_arbiter
   import mux4way_rr_arbiter_pkg::*;
#(
   parameter int unsigned MAX_HOLD = 4,
   parameter int unsigned HOLD_W   = 3
)
(
   input logic              clk,
   input logic              rst_n,
   mux4way_rr_arbiter_if.slave bus
);

   localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(MAX_HOLD);
   localparam logic [HOLD_W-1:0] HOLD_ONE = HOLD_W'(1);

   // First set bit of reqs scanning upward from last+1 with wrap-around;
   // last itself is visited last.
   function automatic rr_pick_t rr_pick(input logic [REQ_N-1:0] reqs,
                                        input logic [SEL_W-1:0] last);
      rr_pick_t         res;
      logic [SEL_W-1:0] cand;
      res = '0;
      for (int k = 1; k <= REQ_N; k++) begin
         cand = last + SEL_W'(k);
         if (!res.found && reqs[cand]) begin
            res.found = 1'b1;
            res.idx   = cand;
         end
      end
      return res;
   endfunction

   arb_state_e        state_q;
   logic [REQ_N-1:0]  grant_q;
   logic [SEL_W-1:0]  select_q;
   logic              grant_valid_q;
   logic [HOLD_W-1:0] hold_cnt_q;
   logic [SEL_W-1:0]  last_winner_q;

   logic [SEL_W-1:0]  owner_idx_s;
   logic [REQ_N-1:0]  others_s;
   logic              owner_req_s;
   logic              hold_full_s;
   rr_pick_t          pick_any_s;
   rr_pick_t          pick_other_s;
   logic              mux_out_s;

   // Arbitration inputs: who owns, who else is waiting, and both scan results.
   always_comb begin
      owner_idx_s  = onehot_to_idx(grant_q);
      others_s     = bus.req & ~grant_q;
      owner_req_s  = |(bus.req & grant_q);
      hold_full_s  = (hold_cnt_q == HOLD_MAX);
      pick_any_s   = rr_pick(bus.req, last_winner_q);
      pick_other_s = rr_pick(others_s, owner_idx_s);
   end

   // Arbiter FSM with registered grant, select, valid and hold count.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= ST_IDLE;
         grant_q       <= 4'b0000;
         select_q      <= 2'b00;
         grant_valid_q <= 1'b0;
         hold_cnt_q    <= {HOLD_W{1'b0}};
         last_winner_q <= 2'b11;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (pick_any_s.found) begin
                  state_q       <= ST_GRANT;
                  grant_q       <= 4'b0001 << pick_any_s.idx;
                  select_q      <= pick_any_s.idx;
                  grant_valid_q <= 1'b1;
                  hold_cnt_q    <= HOLD_ONE;
                  last_winner_q <= pick_any_s.idx;
               end else begin
                  state_q       <= ST_IDLE;
                  grant_q       <= 4'b0000;
                  grant_valid_q <= 1'b0;
                  hold_cnt_q    <= {HOLD_W{1'b0}};
               end
            end
            ST_GRANT: begin
               if (pick_other_s.found && (!owner_req_s || hold_full_s)) begin
                  // Release or hold expiry with a contender: hand over with no bubble.
                  state_q       <= ST_GRANT;
                  grant_q       <= 4'b0001 << pick_other_s.idx;
                  select_q      <= pick_other_s.idx;
                  grant_valid_q <= 1'b1;
                  hold_cnt_q    <= HOLD_ONE;
                  last_winner_q <= pick_other_s.idx;
               end else if (!owner_req_s) begin
                  // Released with nobody waiting; select keeps its last value.
                  state_q       <= ST_IDLE;
                  grant_q       <= 4'b0000;
                  grant_valid_q <= 1'b0;
                  hold_cnt_q    <= {HOLD_W{1'b0}};
               end else if (!hold_full_s) begin
                  hold_cnt_q    <= hold_cnt_q + HOLD_ONE;
               end else begin
                  // Uncontended owner past its limit: keep grant, count saturates.
                  hold_cnt_q    <= HOLD_MAX;
               end
            end
            default: begin
               state_q       <= ST_IDLE;
               grant_q       <= 4'b0000;
               grant_valid_q <= 1'b0;
               hold_cnt_q    <= {HOLD_W{1'b0}};
            end
         endcase
      end
   end

   mux4way u_mux (
      .out    (mux_out_s),
      .select (select_q),
      .inA    (bus.inA),
      .inB    (bus.inB),
      .inC    (bus.inC),
      .inD    (bus.inD)
   );

   assign bus.grant      = grant_q;
   assign bus.select     = select_q;
   assign bus.grantValid = grant_valid_q;
   assign bus.dataOut    = mux_out_s & grant_valid_q;

endmodule

// File: tb/tb_mux4way_rr_arbiter.sv
// Self-checking bench for mux4way_rr_arbiter: a vector table, hand-written
// multi-cycle sequences, and randomized traffic against a reference model.
module tb_mux4way_rr_arbiter;

   localparam int MAX_HOLD = 4;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   mux4way_rr_arbiter_if bus();

   mux4way_rr_arbiter #(.MAX_HOLD(MAX_HOLD), .HOLD_W(3)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   mux4way_rr_arbiter_chk u_chk (
      .clk        (clk),
      .rst_n      (rst_n),
      .grant      (bus.grant),
      .select     (bus.select),
      .grantValid (bus.grantValid)
   );

   int n_cmp  = 0;
   int n_fail = 0;

   // Reference model: owner is -1 when nobody holds the bus.
   int m_owner;
   int m_last;
   int m_hold;
   int m_sel;

   typedef struct {
      logic [3:0] req;
      logic [3:0] din;   // {inD, inC, inB, inA}
      logic [3:0] grant;
      logic [1:0] sel;
      logic       gv;
      logic       dout;
   } vec_t;

   vec_t tbl [10];

   task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic set_in(input logic [3:0] r, input logic [3:0] d);
      bus.req = r;
      {bus.inD, bus.inC, bus.inB, bus.inA} = d;
   endtask

   function automatic int rr_first(input logic [3:0] r, input int from);
      int idx;
      for (int k = 1; k <= 4; k++) begin
         idx = (from + k) % 4;
         if (r[idx[1:0]]) return idx;
      end
      return -1;
   endfunction

   task automatic model_reset();
      m_owner = -1;
      m_last  = 3;
      m_hold  = 0;
      m_sel   = 0;
   endtask

   task automatic model_take(input int w);
      m_owner = w;
      m_sel   = w;
      m_last  = w;
      m_hold  = 1;
   endtask

   // Advance the model by one clock edge seeing request vector r.
   task automatic model_step(input logic [3:0] r);
      int         w;
      logic [3:0] others;
      if (m_owner < 0) begin
         w = rr_first(r, m_last);
         if (w >= 0) model_take(w);
      end else begin
         others = r & ~(4'b0001 << m_owner);
         if (!r[m_owner[1:0]] || m_hold == MAX_HOLD) begin
            w = rr_first(others, m_owner);
            if (w >= 0) model_take(w);
            else if (!r[m_owner[1:0]]) begin
               m_owner = -1;
               m_hold  = 0;
            end
         end else begin
            m_hold = m_hold + 1;
         end
      end
   endtask

   task automatic check_model(input string tag);
      logic [3:0] eg;
      logic [3:0] din_v;
      logic       ed;
      din_v = {bus.inD, bus.inC, bus.inB, bus.inA};
      eg    = (m_owner >= 0) ? (4'b0001 << m_owner) : 4'b0000;
      ed    = (m_owner >= 0) ? din_v[m_owner[1:0]] : 1'b0;
      check({tag, ".grant"},  8'(bus.grant),      8'(eg));
      check({tag, ".select"}, 8'(bus.select),     8'(m_sel[1:0]));
      check({tag, ".valid"},  8'(bus.grantValid), 8'(m_owner >= 0));
      check({tag, ".dout"},   8'(bus.dataOut),    8'(ed));
   endtask

   // One clock: model sees the current request, then outputs are compared.
   task automatic cycle(input string tag);
      model_step(bus.req);
      @(posedge clk);
      #1;
      check_model(tag);
   endtask

   // Asynchronous reset pulse placed between edges; checked without a clock edge.
   task automatic do_reset();
      rst_n = 1'b0;
      #2;
      check("rst.grant",  8'(bus.grant),      8'h00);
      check("rst.select", 8'(bus.select),     8'h00);
      check("rst.valid",  8'(bus.grantValid), 8'h00);
      check("rst.dout",   8'(bus.dataOut),    8'h00);
      model_reset();
      #1;
      rst_n = 1'b1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: time limit reached with %0d compared", n_cmp);
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [3:0] eg;
      logic [3:0] r;
      int         idx;

      tbl[0] = '{4'b0000, 4'b1111, 4'b0000, 2'd0, 1'b0, 1'b0};
      tbl[1] = '{4'b0100, 4'b0100, 4'b0100, 2'd2, 1'b1, 1'b1};
      tbl[2] = '{4'b0100, 4'b0001, 4'b0100, 2'd2, 1'b1, 1'b0};
      tbl[3] = '{4'b0000, 4'b0100, 4'b0000, 2'd2, 1'b0, 1'b0};
      tbl[4] = '{4'b1001, 4'b1000, 4'b1000, 2'd3, 1'b1, 1'b1};
      tbl[5] = '{4'b1001, 4'b0000, 4'b1000, 2'd3, 1'b1, 1'b0};
      tbl[6] = '{4'b0001, 4'b0001, 4'b0001, 2'd0, 1'b1, 1'b1};
      tbl[7] = '{4'b0011, 4'b0010, 4'b0001, 2'd0, 1'b1, 1'b0};
      tbl[8] = '{4'b0010, 4'b0010, 4'b0010, 2'd1, 1'b1, 1'b1};
      tbl[9] = '{4'b0000, 4'b0000, 4'b0000, 2'd1, 1'b0, 1'b0};

      set_in(4'b0000, 4'b0000);
      model_reset();
      #1;
      do_reset();

      // Vector table from reset.
      for (int i = 0; i < 10; i++) begin
         set_in(tbl[i].req, tbl[i].din);
         cycle($sformatf("vec%0d.m", i));
         check($sformatf("vec%0d.grant", i),  8'(bus.grant),      8'(tbl[i].grant));
         check($sformatf("vec%0d.select", i), 8'(bus.select),     8'(tbl[i].sel));
         check($sformatf("vec%0d.valid", i),  8'(bus.grantValid), 8'(tbl[i].gv));
         check($sformatf("vec%0d.dout", i),   8'(bus.dataOut),    8'(tbl[i].dout));
      end

      // Reset asserted mid-grant, then released with a single request.
      do_reset();
      set_in(4'b1111, 4'b0000);
      for (int k = 0; k < 3; k++) begin
         cycle("midrst.m");
         check("midrst.grant", 8'(bus.grant), 8'h01);
      end
      #2;
      rst_n   = 1'b0;
      bus.inA = 1'b1;
      #1;
      check("midrst.r.grant",  8'(bus.grant),      8'h00);
      check("midrst.r.select", 8'(bus.select),     8'h00);
      check("midrst.r.valid",  8'(bus.grantValid), 8'h00);
      check("midrst.r.dout",   8'(bus.dataOut),    8'h00);
      model_reset();
      bus.req = 4'b0010;
      #1;
      rst_n = 1'b1;
      cycle("midrst.rel.m");
      check("midrst.rel.grant", 8'(bus.grant), 8'h02);

      // Full contention: four cycles per owner, then back to requester 0.
      do_reset();
      set_in(4'b1111, 4'b1010);
      for (int k = 1; k <= 17; k++) begin
         cycle("contend.m");
         idx = (k <= 16) ? ((k - 1) / 4) % 4 : 0;
         eg  = 4'b0001 << idx;
         check($sformatf("contend%0d.grant", k), 8'(bus.grant), 8'(eg));
      end

      // Uncontended overrun, then a contender wins immediately.
      do_reset();
      set_in(4'b0001, 4'b0001);
      for (int k = 0; k < 10; k++) begin
         cycle("overrun.m");
         check("overrun.grant", 8'(bus.grant), 8'h01);
      end
      set_in(4'b0011, 4'b0001);
      cycle("overrun.sw.m");
      check("overrun.sw.grant", 8'(bus.grant), 8'h02);

      // Idle after owner 0 releases, then wrap-around pick.
      do_reset();
      set_in(4'b0001, 4'b0000);
      cycle("wrap.own.m");
      set_in(4'b0000, 4'b0001);
      cycle("wrap.idle.m");
      check("wrap.idle.grant",  8'(bus.grant),      8'h00);
      check("wrap.idle.valid",  8'(bus.grantValid), 8'h00);
      check("wrap.idle.dout",   8'(bus.dataOut),    8'h00);
      check("wrap.idle.select", 8'(bus.select),     8'h00);
      set_in(4'b1001, 4'b0001);
      cycle("wrap.pick.m");
      check("wrap.pick.grant", 8'(bus.grant), 8'h08);

      // Randomized traffic against the model.
      do_reset();
      r = 4'b0000;
      for (int k = 0; k < 400; k++) begin
         if ($urandom_range(0, 1) == 0) r = 4'($urandom_range(0, 15));
         set_in(r, 4'($urandom_range(0, 15)));
         cycle("rand");
         if ($urandom_range(0, 59) == 0) do_reset();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
